// File: rtl/player_move_controller.sv
// Snakes-and-ladders move sequencer: validates a dice roll, steps the active
// token one square per STEP_DELAY cycles, applies the board table, then hands over the turn.
module player_move_controller #(
  parameter int unsigned STEP_DELAY = 25_000_000
) (
  input  logic       clock,
  input  logic       Clear_b,
  input  logic       roll_valid,
  input  logic [3:0] dice_value,
  output logic [6:0] p1_pos,
  output logic [6:0] p2_pos,
  output logic       current_player,
  output logic       busy,
  output logic       move_done,
  output logic       jumped,
  output logic       bad_roll,
  output logic       winner_valid,
  output logic       winner
);

  localparam int unsigned CW = (STEP_DELAY > 1) ? $clog2(STEP_DELAY) : 1;
  localparam logic [CW-1:0] RELOAD = CW'(STEP_DELAY - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CHECK = 3'd1;
  localparam logic [2:0] S_MOVE  = 3'd2;
  localparam logic [2:0] S_JUMP  = 3'd3;
  localparam logic [2:0] S_DONE  = 3'd4;
  localparam logic [2:0] S_WON   = 3'd5;

  logic [2:0]    state;
  logic [2:0]    d;
  logic [2:0]    remaining;
  logic [CW-1:0] cnt;
  logic          jump_flag;
  logic          overshoot;

  logic [6:0]    cur_pos;
  logic [6:0]    target;
  logic          roll_legal;
  logic          jump_hit;
  logic [6:0]    jump_dest;

  assign cur_pos    = current_player ? p2_pos : p1_pos;
  assign target     = cur_pos + {4'b0000, d};
  assign roll_legal = (dice_value >= 4'd1) && (dice_value <= 4'd6);

  always_comb begin
    jump_hit  = 1'b1;
    jump_dest = cur_pos;
    case (cur_pos)
      // ladders
      7'd4:    jump_dest = 7'd14;
      7'd9:    jump_dest = 7'd31;
      7'd21:   jump_dest = 7'd42;
      7'd28:   jump_dest = 7'd84;
      7'd51:   jump_dest = 7'd67;
      7'd72:   jump_dest = 7'd91;
      7'd80:   jump_dest = 7'd99;
      // snakes
      7'd17:   jump_dest = 7'd7;
      7'd54:   jump_dest = 7'd34;
      7'd62:   jump_dest = 7'd19;
      7'd64:   jump_dest = 7'd60;
      7'd87:   jump_dest = 7'd36;
      7'd93:   jump_dest = 7'd73;
      7'd95:   jump_dest = 7'd75;
      7'd98:   jump_dest = 7'd79;
      default: jump_hit  = 1'b0;
    endcase
  end

  always_ff @(posedge clock or negedge Clear_b) begin
    if (!Clear_b) begin
      state          <= S_IDLE;
      d              <= '0;
      remaining      <= '0;
      cnt            <= '0;
      jump_flag      <= 1'b0;
      overshoot      <= 1'b0;
      p1_pos         <= '0;
      p2_pos         <= '0;
      current_player <= 1'b0;
      bad_roll       <= 1'b0;
      winner_valid   <= 1'b0;
      winner         <= 1'b0;
    end else begin
      bad_roll <= 1'b0;
      case (state)
        S_IDLE: begin
          if (roll_valid) begin
            if (roll_legal) begin
              d     <= dice_value[2:0];
              state <= S_CHECK;
            end else begin
              bad_roll <= 1'b1;
            end
          end
        end
        S_CHECK: begin
          jump_flag <= 1'b0;
          if (target > 7'd100) begin
            overshoot <= 1'b1;
            state     <= S_DONE;
          end else begin
            overshoot <= 1'b0;
            remaining <= d;
            cnt       <= RELOAD;
            state     <= S_MOVE;
          end
        end
        S_MOVE: begin
          if (cnt == '0) begin
            if (current_player)
              p2_pos <= p2_pos + 7'd1;
            else
              p1_pos <= p1_pos + 7'd1;
            remaining <= remaining - 3'd1;
            cnt       <= RELOAD;
            if (remaining == 3'd1)
              state <= S_JUMP;
          end else begin
            cnt <= cnt - CW'(1);
          end
        end
        S_JUMP: begin
          if (jump_hit) begin
            if (current_player)
              p2_pos <= jump_dest;
            else
              p1_pos <= jump_dest;
            jump_flag <= 1'b1;
          end
          state <= S_DONE;
        end
        S_DONE: begin
          if (cur_pos == 7'd100) begin
            winner       <= current_player;
            winner_valid <= 1'b1;
            state        <= S_WON;
          end else begin
            // a full six keeps the turn; an overshot six does not
            if (!((d == 3'd6) && !overshoot))
              current_player <= ~current_player;
            state <= S_IDLE;
          end
        end
        S_WON: state <= S_WON;
        default: state <= S_IDLE;
      endcase
    end
  end

  assign busy      = (state != S_IDLE) && (state != S_WON);
  assign move_done = (state == S_DONE);
  assign jumped    = move_done && jump_flag;

endmodule

// File: tb/tb_player_move_controller.sv
// Directed bench for player_move_controller: one STEP_DELAY=1 instance for game flow
// and one STEP_DELAY=4 instance for the mid-move asynchronous reset.
module tb_player_move_controller;

  logic       clock;
  logic       Clear_b, roll_valid;
  logic [3:0] dice_value;
  logic [6:0] p1_pos, p2_pos;
  logic       current_player, busy, move_done, jumped, bad_roll, winner_valid, winner;

  logic       Clear_b4, roll_valid4;
  logic [3:0] dice_value4;
  logic [6:0] p1_pos4, p2_pos4;
  logic       current_player4, busy4, move_done4, jumped4, bad_roll4, winner_valid4, winner4;

  int n_checks = 0;
  int n_fail   = 0;

  player_move_controller #(.STEP_DELAY(1)) dut (
    .clock(clock), .Clear_b(Clear_b), .roll_valid(roll_valid), .dice_value(dice_value),
    .p1_pos(p1_pos), .p2_pos(p2_pos), .current_player(current_player), .busy(busy),
    .move_done(move_done), .jumped(jumped), .bad_roll(bad_roll),
    .winner_valid(winner_valid), .winner(winner)
  );

  player_move_controller #(.STEP_DELAY(4)) dut4 (
    .clock(clock), .Clear_b(Clear_b4), .roll_valid(roll_valid4), .dice_value(dice_value4),
    .p1_pos(p1_pos4), .p2_pos(p2_pos4), .current_player(current_player4), .busy(busy4),
    .move_done(move_done4), .jumped(jumped4), .bad_roll(bad_roll4),
    .winner_valid(winner_valid4), .winner(winner4)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic reset_dut();
    @(negedge clock);
    Clear_b = 1'b0;
    repeat (2) @(negedge clock);
    Clear_b = 1'b1;
    @(negedge clock);
  endtask

  // drive one roll; returns at the negedge after the sampling edge
  task automatic roll(input logic [3:0] v);
    @(negedge clock);
    roll_valid = 1'b1;
    dice_value = v;
    @(negedge clock);
    roll_valid = 1'b0;
    dice_value = 4'd0;
  endtask

  task automatic roll4(input logic [3:0] v);
    @(negedge clock);
    roll_valid4 = 1'b1;
    dice_value4 = v;
    @(negedge clock);
    roll_valid4 = 1'b0;
    dice_value4 = 4'd0;
  endtask

  // full turn on dut; returns one cycle after move_done, with jumped captured
  task automatic do_turn(input logic [3:0] v, output logic timed_out, output logic jmp);
    int i;
    roll(v);
    timed_out = 1'b1;
    jmp = 1'b0;
    i = 0;
    while (timed_out && i < 64) begin
      if (move_done === 1'b1) begin
        timed_out = 1'b0;
        jmp = jumped;
      end else begin
        @(negedge clock);
        i++;
      end
    end
    if (!timed_out) @(negedge clock);
  endtask

  task automatic test_reset();
    #2;
    Clear_b = 1'b0;
    Clear_b4 = 1'b0;
    #1;
    n_checks++; if ({p1_pos, p2_pos, current_player, busy, move_done, jumped, bad_roll, winner_valid, winner} !== 21'd0) begin n_fail++; $display("FAIL reset_outputs: got %h expected 0", {p1_pos, p2_pos, current_player, busy, move_done, jumped, bad_roll, winner_valid, winner}); end
    repeat (2) @(negedge clock);
    Clear_b = 1'b1;
    Clear_b4 = 1'b1;
    @(negedge clock);
    n_checks++; if ({p1_pos, p2_pos, current_player, busy} !== 16'd0) begin n_fail++; $display("FAIL reset_release: got %h expected 0", {p1_pos, p2_pos, current_player, busy}); end
  endtask

  task automatic test_plain_move();
    reset_dut();
    roll(4'd3);
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL plain_busy_rise: got %b expected 1", busy); end
    @(negedge clock);
    n_checks++; if (p1_pos !== 7'd0) begin n_fail++; $display("FAIL plain_e1: got %0d expected 0", p1_pos); end
    @(negedge clock);
    n_checks++; if (p1_pos !== 7'd1) begin n_fail++; $display("FAIL plain_e2: got %0d expected 1", p1_pos); end
    @(negedge clock);
    n_checks++; if (p1_pos !== 7'd2) begin n_fail++; $display("FAIL plain_e3: got %0d expected 2", p1_pos); end
    @(negedge clock);
    n_checks++; if ({p1_pos, move_done} !== {7'd3, 1'b0}) begin n_fail++; $display("FAIL plain_e4: got pos %0d done %b expected 3 0", p1_pos, move_done); end
    @(negedge clock);
    n_checks++; if ({move_done, jumped, current_player} !== 3'b100) begin n_fail++; $display("FAIL plain_done: got %b expected 100", {move_done, jumped, current_player}); end
    @(negedge clock);
    n_checks++; if ({move_done, busy, current_player, p1_pos, p2_pos} !== {3'b001, 7'd3, 7'd0}) begin n_fail++; $display("FAIL plain_after: got done/busy/cp %b p1 %0d p2 %0d expected 001 3 0", {move_done, busy, current_player}, p1_pos, p2_pos); end
  endtask

  task automatic test_ladder_snake();
    logic to, to_any, jmp;
    to_any = 1'b0;
    reset_dut();
    do_turn(4'd4, to, jmp); to_any |= to;
    n_checks++; if ({p1_pos, jmp, current_player} !== {7'd14, 1'b1, 1'b1}) begin n_fail++; $display("FAIL ladder_4: got p1 %0d jumped %b cp %b expected 14 1 1", p1_pos, jmp, current_player); end
    do_turn(4'd5, to, jmp); to_any |= to;
    n_checks++; if ({p2_pos, jmp, current_player} !== {7'd5, 1'b0, 1'b0}) begin n_fail++; $display("FAIL p2_roll5: got p2 %0d jumped %b cp %b expected 5 0 0", p2_pos, jmp, current_player); end
    do_turn(4'd1, to, jmp); to_any |= to;
    n_checks++; if ({p1_pos, current_player} !== {7'd15, 1'b1}) begin n_fail++; $display("FAIL p1_roll1: got p1 %0d cp %b expected 15 1", p1_pos, current_player); end
    do_turn(4'd6, to, jmp); to_any |= to;
    n_checks++; if ({p2_pos, current_player} !== {7'd11, 1'b1}) begin n_fail++; $display("FAIL p2_six_keep: got p2 %0d cp %b expected 11 1", p2_pos, current_player); end
    do_turn(4'd6, to, jmp); to_any |= to;
    n_checks++; if ({p2_pos, jmp, current_player, p1_pos} !== {7'd7, 1'b1, 1'b1, 7'd15}) begin n_fail++; $display("FAIL snake_17: got p2 %0d jumped %b cp %b p1 %0d expected 7 1 1 15", p2_pos, jmp, current_player, p1_pos); end
    n_checks++; if (to_any !== 1'b0) begin n_fail++; $display("FAIL ladder_snake_timeout: got %b expected 0", to_any); end
  endtask

  task automatic test_extra_turn();
    logic to, jmp;
    reset_dut();
    do_turn(4'd6, to, jmp);
    n_checks++; if ({to, p1_pos, current_player} !== {1'b0, 7'd6, 1'b0}) begin n_fail++; $display("FAIL six_extra: got to %b p1 %0d cp %b expected 0 6 0", to, p1_pos, current_player); end
    do_turn(4'd2, to, jmp);
    n_checks++; if ({to, p1_pos, current_player} !== {1'b0, 7'd8, 1'b1}) begin n_fail++; $display("FAIL after_extra: got to %b p1 %0d cp %b expected 0 8 1", to, p1_pos, current_player); end
  endtask

  task automatic test_overshoot_win();
    logic to, to_any, jmp;
    logic [3:0] seq [10];
    seq = '{4'd4, 4'd1, 4'd6, 4'd6, 4'd2, 4'd1, 4'd6, 4'd6, 4'd1, 4'd1};
    to_any = 1'b0;
    reset_dut();
    for (int i = 0; i < 10; i++) begin
      do_turn(seq[i], to, jmp);
      to_any |= to;
    end
    n_checks++; if ({to_any, p1_pos, p2_pos, current_player} !== {1'b0, 7'd97, 7'd3, 1'b0}) begin n_fail++; $display("FAIL preload: got to %b p1 %0d p2 %0d cp %b expected 0 97 3 0", to_any, p1_pos, p2_pos, current_player); end
    roll(4'd5);
    n_checks++; if ({busy, move_done} !== 2'b10) begin n_fail++; $display("FAIL overshoot_check: got busy/done %b expected 10", {busy, move_done}); end
    @(negedge clock);
    n_checks++; if ({move_done, jumped, current_player, p1_pos} !== {3'b100, 7'd97}) begin n_fail++; $display("FAIL overshoot_done: got done/j/cp %b p1 %0d expected 100 97", {move_done, jumped, current_player}, p1_pos); end
    @(negedge clock);
    n_checks++; if ({move_done, busy, current_player, p1_pos} !== {3'b001, 7'd97}) begin n_fail++; $display("FAIL overshoot_pass: got done/busy/cp %b p1 %0d expected 001 97", {move_done, busy, current_player}, p1_pos); end
    do_turn(4'd1, to, jmp);
    n_checks++; if ({to, p2_pos, jmp, current_player} !== {1'b0, 7'd14, 1'b1, 1'b0}) begin n_fail++; $display("FAIL p2_ladder: got to %b p2 %0d jumped %b cp %b expected 0 14 1 0", to, p2_pos, jmp, current_player); end
    do_turn(4'd3, to, jmp);
    n_checks++; if ({to, p1_pos, winner_valid, winner, busy, current_player} !== {1'b0, 7'd100, 4'b1000}) begin n_fail++; $display("FAIL win: got to %b p1 %0d wv/w/busy/cp %b expected 0 100 1000", to, p1_pos, {winner_valid, winner, busy, current_player}); end
    roll(4'd2);
    n_checks++; if ({busy, bad_roll} !== 2'b00) begin n_fail++; $display("FAIL won_roll_busy: got busy/bad %b expected 00", {busy, bad_roll}); end
    roll(4'd9);
    n_checks++; if (bad_roll !== 1'b0) begin n_fail++; $display("FAIL won_bad_roll: got %b expected 0", bad_roll); end
    repeat (8) @(negedge clock);
    n_checks++; if ({p1_pos, p2_pos, winner_valid, winner, current_player, busy} !== {7'd100, 7'd14, 4'b1000}) begin n_fail++; $display("FAIL won_frozen: got p1 %0d p2 %0d wv/w/cp/busy %b expected 100 14 1000", p1_pos, p2_pos, {winner_valid, winner, current_player, busy}); end
  endtask

  task automatic test_illegal_ignored();
    reset_dut();
    roll(4'd7);
    n_checks++; if ({bad_roll, busy} !== 2'b10) begin n_fail++; $display("FAIL bad7_pulse: got bad/busy %b expected 10", {bad_roll, busy}); end
    @(negedge clock);
    n_checks++; if ({bad_roll, busy, p1_pos, current_player} !== {2'b00, 7'd0, 1'b0}) begin n_fail++; $display("FAIL bad7_after: got bad/busy %b p1 %0d cp %b expected 00 0 0", {bad_roll, busy}, p1_pos, current_player); end
    roll(4'd0);
    n_checks++; if ({bad_roll, busy} !== 2'b10) begin n_fail++; $display("FAIL bad0_pulse: got bad/busy %b expected 10", {bad_roll, busy}); end
    @(negedge clock);
    n_checks++; if (bad_roll !== 1'b0) begin n_fail++; $display("FAIL bad0_single: got %b expected 0", bad_roll); end
    roll(4'd3);
    @(negedge clock);
    @(negedge clock);
    n_checks++; if (p1_pos !== 7'd1) begin n_fail++; $display("FAIL move_e2: got %0d expected 1", p1_pos); end
    roll_valid = 1'b1;
    dice_value = 4'd5;
    @(negedge clock);
    roll_valid = 1'b0;
    dice_value = 4'd0;
    n_checks++; if ({p1_pos, bad_roll} !== {7'd2, 1'b0}) begin n_fail++; $display("FAIL move_ignore_e3: got p1 %0d bad %b expected 2 0", p1_pos, bad_roll); end
    @(negedge clock);
    n_checks++; if ({p1_pos, move_done} !== {7'd3, 1'b0}) begin n_fail++; $display("FAIL move_ignore_e4: got p1 %0d done %b expected 3 0", p1_pos, move_done); end
    @(negedge clock);
    n_checks++; if (move_done !== 1'b1) begin n_fail++; $display("FAIL move_ignore_done: got %b expected 1", move_done); end
    roll_valid = 1'b1;
    dice_value = 4'd2;
    @(negedge clock);
    roll_valid = 1'b0;
    dice_value = 4'd0;
    n_checks++; if ({busy, p1_pos, current_player} !== {1'b0, 7'd3, 1'b1}) begin n_fail++; $display("FAIL done_roll_ignored: got busy %b p1 %0d cp %b expected 0 3 1", busy, p1_pos, current_player); end
  endtask

  task automatic test_reset_mid_move();
    int i;
    logic seen, jmp;
    roll4(4'd5);
    repeat (9) @(negedge clock);
    n_checks++; if (p1_pos4 !== 7'd2) begin n_fail++; $display("FAIL slow_e9: got %0d expected 2", p1_pos4); end
    repeat (2) @(negedge clock);
    Clear_b4 = 1'b0;
    #1;
    n_checks++; if ({p1_pos4, p2_pos4, current_player4, busy4, move_done4, jumped4, bad_roll4, winner_valid4, winner4} !== 21'd0) begin n_fail++; $display("FAIL midmove_reset: got %h expected 0", {p1_pos4, p2_pos4, current_player4, busy4, move_done4, jumped4, bad_roll4, winner_valid4, winner4}); end
    @(negedge clock);
    Clear_b4 = 1'b1;
    roll4(4'd2);
    seen = 1'b0;
    jmp = 1'b0;
    i = 0;
    while (!seen && i < 64) begin
      if (move_done4 === 1'b1) begin
        seen = 1'b1;
        jmp = jumped4;
      end else begin
        @(negedge clock);
        i++;
      end
    end
    @(negedge clock);
    n_checks++; if ({seen, p1_pos4, jmp, current_player4, busy4} !== {1'b1, 7'd2, 3'b010}) begin n_fail++; $display("FAIL after_reset_roll: got seen %b p1 %0d j/cp/busy %b expected 1 2 010", seen, p1_pos4, {jmp, current_player4, busy4}); end
  endtask

  initial begin
    Clear_b = 1'b1;
    Clear_b4 = 1'b1;
    roll_valid = 1'b0;
    dice_value = 4'd0;
    roll_valid4 = 1'b0;
    dice_value4 = 4'd0;
    test_reset();
    test_plain_move();
    test_ladder_snake();
    test_extra_turn();
    test_overshoot_win();
    test_illegal_ignored();
    test_reset_mid_move();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/player_move_controller.md
# player_move_controller

Consumes the dice value produced by the dice roller and advances the active player's token on the 100-square snakes-and-ladders board, one square per animation interval. It applies the fixed snake/ladder table, alternates turns and detects the winner. It sits between the dice roller, whose `diceNumber` feeds `dice_value`, and the board/HEX display logic, which reads the positions and flags.

## Interface

**Parameters**
- `STEP_DELAY`, default 25_000_000: clock cycles per one-square step. Legal range ≥1; use 1 in simulation.

**Ports**
- `clock`, in, 1: system clock; all state updates on the rising edge.
- `Clear_b`, in, 1: reset. One clock; reset is asynchronous and active-low.
- `roll_valid`, in, 1: single-cycle pulse; `dice_value` is valid in the same cycle.
- `dice_value`, in, 4: dice result. Only 1..6 is legal.
- `p1_pos`, out, 7: player-1 square, 0 (off board) to 100.
- `p2_pos`, out, 7: player-2 square, 0 to 100.
- `current_player`, out, 1: 0 = player 1, 1 = player 2.
- `busy`, out, 1: high in every state except IDLE and WON.
- `move_done`, out, 1: one-cycle pulse at the end of each accepted roll.
- `jumped`, out, 1: high with `move_done` when a snake or ladder was applied.
- `bad_roll`, out, 1: one-cycle pulse when `roll_valid` carries an illegal value.
- `winner_valid`, out, 1: high once a player reaches 100; sticky until reset.
- `winner`, out, 1: the winning player; meaningful only while `winner_valid` is high.

## Operation

**Reset.** Every output is 0: positions 0, player 1 active, all flags low. State is IDLE. Reset asserted mid-move aborts immediately, with no partial update retained.

**States.** IDLE, CHECK, MOVE, JUMP, DONE, WON.

**IDLE**
- On `roll_valid` with `dice_value` in 1..6: latch `d`, go to CHECK.
- On `roll_valid` with `dice_value` of 0 or 7..15: pulse `bad_roll` on the next cycle and stay in IDLE.
- `roll_valid` is ignored in every state other than IDLE.

**CHECK**
- Let `target = pos + d`, computed 7 bits wide; the maximum is 106, so there is no overflow.
- If `target` > 100 (overshoot): go to DONE with no move. The turn always passes.
- Otherwise: go to MOVE, remaining = `d`, delay counter = `STEP_DELAY`-1.

**MOVE**
- The delay counter decrements each cycle.
- At 0: the active position increments by 1, remaining decrements, and the counter reloads.
- When the last step is taken, go to JUMP.

**JUMP**
- Exactly one lookup, with no chaining.
- Ladders: 4→14, 9→31, 21→42, 28→84, 51→67, 72→91, 80→99.
- Snakes: 17→7, 54→34, 62→19, 64→60, 87→36, 93→73, 95→75, 98→79.
- If the position matches an entry, replace it with the destination and set the `jumped` flag.
- Go to DONE.

**DONE**
- `move_done` is high for this one cycle; `jumped` is valid with it.
- If the position is 100: `winner` = `current_player`, `winner_valid` = 1, go to WON.
- Otherwise, `current_player` toggles unless `d` == 6 and no overshoot occurred (extra turn). Go to IDLE.

**WON.** Terminal state. Positions and winner are frozen and rolls are ignored until `Clear_b`.

Only the active player's position ever changes.

## Timing

All edge counts below are measured from the edge that samples `roll_valid` (edge 0).

- CHECK occupies the cycle after edge 0. The MOVE decision is taken at edge 1.
- Position increments land at edges 1+k·`STEP_DELAY`, for k = 1..`d`.
- The jump is applied at edge `d`·`STEP_DELAY`+2.
- `move_done` is high during the cycle after edge `d`·`STEP_DELAY`+2, which is the DONE state.
- `current_player` and `winner_valid` update at edge `d`·`STEP_DELAY`+3.
- Overshoot path: `move_done` is high during the cycle after edge 1. The player toggles at edge 2.
- `bad_roll` is high during the cycle after edge 0.
- `busy` rises at edge 0 and falls with the DONE→IDLE edge.
- A `roll_valid` arriving in the same cycle as `move_done` is ignored, because the state is still DONE.

## Test plan

1. **Plain move.** `STEP_DELAY`=1. After reset, roll 3. Expect `p1_pos` 0→1→2→3 on consecutive edges 2–4, `move_done` after edge 5 with `jumped`=0, then `current_player`=1.
2. **Ladder and snake.** Player 1 rolls 4: lands on 4, JUMP gives 14, `jumped`=1. Player 2 reaches 17 via rolls 5, 6, 6: the first 6 lands on 11 and keeps the turn; 11+6=17 snakes to 7. Expect `p2_pos`=7 and `jumped`=1 on that move.
3. **Extra turn on 6.** Player 1 rolls 6: `p1_pos`=6 and `current_player` stays 0. The next roll of 2 gives 8, then `current_player`=1.
4. **Overshoot and win.** Preload player 1 at 97 via a roll sequence, roll 5: no move, `move_done` 2 edges after the roll, turn passes. Later roll 3 from 97: position 100, `winner_valid`=1, `winner`=0. A further `roll_valid` changes nothing.
5. **Illegal and ignored rolls.** `dice_value`=7 in IDLE: `bad_roll` pulses once and state is unchanged. `dice_value`=0: same. `roll_valid` during MOVE: no effect on `d` or timing.
6. **Reset mid-move.** `STEP_DELAY`=4, roll 5, drop `Clear_b` during the third step. All outputs are 0 immediately, with no clock edge required. After release, a roll of 2 gives `p1_pos`=2.
